// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter, three requesters into one registered write port
module wb_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         req_valid,
    output logic [2:0]         req_ready,
    input  logic [2:0]         req_gf,
    input  logic [14:0]        req_num,
    input  logic [3*WIDTH-1:0] req_data,
    input  logic               wb_stall,
    output logic               r_gfflag,
    output logic [4:0]         r_num,
    output logic [WIDTH-1:0]   r_data,
    output logic               enable
);

    localparam int NREQ = 3;

    logic [1:0]       ptr_q, ptr_d;
    logic             en_q, en_d;
    logic             gf_q, gf_d;
    logic [4:0]       num_q, num_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [1:0]       idx;
    logic             sel_gf;
    logic [4:0]       sel_num;
    logic [WIDTH-1:0] sel_data;
    logic             wr_ok;

    function automatic logic [1:0] wrap3(input logic [2:0] s);
        logic [2:0] t;
        t = (s >= 3'd3) ? s - 3'd3 : s;
        return t[1:0];
    endfunction

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        idx       = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = wrap3({1'b0, ptr_q} + 3'(k));
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (rst || wb_stall) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = 3'b000;
        if (grant_any) begin
            req_ready = 3'b001 << grant_idx;
        end
    end

    always_comb begin
        sel_gf   = req_gf[grant_idx];
        sel_num  = req_num[int'(grant_idx) * 5 +: 5];
        sel_data = req_data[int'(grant_idx) * WIDTH +: WIDTH];
    end

    // General register 0 is hard-wired zero: the write is consumed but never issued.
    assign wr_ok = grant_any && (sel_gf || (sel_num != 5'd0));

    always_comb begin
        ptr_d  = ptr_q;
        en_d   = 1'b0;
        gf_d   = 1'b0;
        num_d  = 5'd0;
        data_d = '0;
        if (grant_any) begin
            ptr_d = wrap3({1'b0, grant_idx} + 3'd1);
        end
        if (wr_ok) begin
            en_d   = 1'b1;
            gf_d   = sel_gf;
            num_d  = sel_num;
            data_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= 2'd0;
            en_q   <= 1'b0;
            gf_q   <= 1'b0;
            num_q  <= 5'd0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            en_q   <= en_d;
            gf_q   <= gf_d;
            num_q  <= num_d;
            data_q <= data_d;
        end
    end

    assign enable   = en_q;
    assign r_gfflag = gf_q;
    assign r_num    = num_q;
    assign r_data   = data_q;

endmodule
